// File: rtl/dcpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcpu_pkg
// Description : Shared definitions for the DCPU bus arbiter: arbiter state
//               encoding, master identifiers and the bus data width.
// Revision    : 1.0 - initial release
// ============================================================================
package dcpu_pkg;

    // Width of every address and data path on the shared bus.
    localparam int c_BUS_W = 16;

    // Master identifiers; also the encoding of the round-robin "last served"
    // pointer.
    localparam logic c_M0_ID = 1'b0;
    localparam logic c_M1_ID = 1'b1;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

endpackage : dcpu_pkg
`default_nettype wire

// File: rtl/dcpu_bus_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcpu_bus_timer
// Description : 8-bit grant-age counter for the bus arbiter. It is cleared
//               while the bus is idle and counts every granted cycle.
//               o_term is high when the count reaches TIMEOUT-1, which is the
//               TIMEOUT-th granted cycle of a transfer.
// Ports       : i_clk      - system clock
//               i_reset_n  - asynchronous active-low reset
//               i_clr      - clear counter (has priority over i_inc)
//               i_inc      - increment counter
//               o_term     - terminal count reached
// Revision    : 1.0 - initial release
// ============================================================================
module dcpu_bus_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam logic [7:0] c_TERM = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    // The arbiter leaves the grant state on the terminal cycle, so the count
    // never runs past c_TERM and needs no saturation.
    assign o_term = (r_count == c_TERM);

endmodule : dcpu_bus_timer
`default_nettype wire

// File: rtl/dcpu_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcpu_bus_arbiter
// Description : Two-master, one-slave bus arbiter. Master 0 is the CPU,
//               master 1 a secondary master. Simultaneous requests are
//               resolved round-robin; a granted transfer ends on slave ack,
//               master withdrawal or timeout. One idle cycle separates
//               consecutive transfers.
// Ports       : i_clk, i_reset_n             - clock, async active-low reset
//               i_mN_addr/dat/we/cs          - master N request
//               o_mN_dat/ack/err             - master N response
//               o_s_addr/dat/we/cs           - slave request
//               i_s_dat, i_s_ack             - slave response
//               o_grant                      - registered one-hot grant {m1,m0}
// Revision    : 1.0 - initial release
// ============================================================================
module dcpu_bus_arbiter
    import dcpu_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int M0_PRIO = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    // master 0 (CPU)
    input  logic [c_BUS_W-1:0] i_m0_addr,
    input  logic [c_BUS_W-1:0] i_m0_dat,
    input  logic               i_m0_we,
    input  logic               i_m0_cs,
    output logic [c_BUS_W-1:0] o_m0_dat,
    output logic               o_m0_ack,
    output logic               o_m0_err,
    // master 1
    input  logic [c_BUS_W-1:0] i_m1_addr,
    input  logic [c_BUS_W-1:0] i_m1_dat,
    input  logic               i_m1_we,
    input  logic               i_m1_cs,
    output logic [c_BUS_W-1:0] o_m1_dat,
    output logic               o_m1_ack,
    output logic               o_m1_err,
    // slave
    output logic [c_BUS_W-1:0] o_s_addr,
    output logic [c_BUS_W-1:0] o_s_dat,
    output logic               o_s_we,
    output logic               o_s_cs,
    input  logic [c_BUS_W-1:0] i_s_dat,
    input  logic               i_s_ack,
    // status
    output logic [1:0]         o_grant
);

    localparam logic [c_BUS_W-1:0] c_ERR_DAT = 16'hFFFF;
    // Pointer holds the last-served master; resetting it to master 1 makes
    // master 0 win the first contended arbitration.
    localparam logic c_LAST_RST = (M0_PRIO != 0) ? c_M1_ID : c_M0_ID;

    state_t             r_state;
    logic               r_last;
    logic [1:0]         r_grant;

    logic               w_granted;
    logic               w_sel;
    logic               w_cs_sel;
    logic               w_we_sel;
    logic [c_BUS_W-1:0] w_addr_sel;
    logic [c_BUS_W-1:0] w_dat_sel;
    logic               w_term;
    logic               w_ack;
    logic               w_tmo;
    logic               w_done;
    logic [c_BUS_W-1:0] w_rd_dat;

    // ------------------------------------------------------------------------
    // Grant-age timer
    // ------------------------------------------------------------------------
    dcpu_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (~w_granted),
        .i_inc     (w_granted),
        .o_term    (w_term)
    );

    // ------------------------------------------------------------------------
    // Granted-master selection and transfer completion
    // ------------------------------------------------------------------------
    assign w_granted  = (r_state != ST_IDLE);
    assign w_sel      = (r_state == ST_GRANT1);
    assign w_cs_sel   = w_sel ? i_m1_cs   : i_m0_cs;
    assign w_we_sel   = w_sel ? i_m1_we   : i_m0_we;
    assign w_addr_sel = w_sel ? i_m1_addr : i_m0_addr;
    assign w_dat_sel  = w_sel ? i_m1_dat  : i_m0_dat;

    // A slave ack only counts while the master still requests. A timeout is
    // raised only when no ack arrives in the terminal cycle (ack wins), and
    // only while the master requests (withdrawal ends quietly).
    assign w_ack    = w_granted & w_cs_sel & i_s_ack;
    assign w_tmo    = w_granted & w_cs_sel & ~i_s_ack & w_term;
    assign w_done   = w_ack | w_tmo;
    assign w_rd_dat = w_tmo ? c_ERR_DAT : i_s_dat;

    // ------------------------------------------------------------------------
    // Slave-side forwarding (zero while idle)
    // ------------------------------------------------------------------------
    assign o_s_cs   = w_granted & w_cs_sel;
    assign o_s_we   = w_granted & w_cs_sel & w_we_sel;
    assign o_s_addr = w_granted ? w_addr_sel : '0;
    assign o_s_dat  = w_granted ? w_dat_sel  : '0;

    // ------------------------------------------------------------------------
    // Master-side responses; only the granted master sees anything
    // ------------------------------------------------------------------------
    assign o_m0_ack = (r_state == ST_GRANT0) & w_done;
    assign o_m0_err = (r_state == ST_GRANT0) & w_tmo;
    assign o_m0_dat = (r_state == ST_GRANT0) ? w_rd_dat : '0;

    assign o_m1_ack = (r_state == ST_GRANT1) & w_done;
    assign o_m1_err = (r_state == ST_GRANT1) & w_tmo;
    assign o_m1_dat = (r_state == ST_GRANT1) ? w_rd_dat : '0;

    assign o_grant  = r_grant;

    // ------------------------------------------------------------------------
    // Arbitration FSM; o_grant is registered alongside the state so it always
    // equals the state decode.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_last  <= c_LAST_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_m0_cs && i_m1_cs) begin
                        if (r_last == c_M1_ID) begin
                            r_state <= ST_GRANT0;
                            r_grant <= 2'b01;
                        end else begin
                            r_state <= ST_GRANT1;
                            r_grant <= 2'b10;
                        end
                    end else if (i_m0_cs) begin
                        r_state <= ST_GRANT0;
                        r_grant <= 2'b01;
                    end else if (i_m1_cs) begin
                        r_state <= ST_GRANT1;
                        r_grant <= 2'b10;
                    end
                end

                ST_GRANT0, ST_GRANT1: begin
                    if (w_done) begin
                        // Completed (acked or timed out): this master becomes
                        // the last served.
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                        r_last  <= w_sel;
                    end else if (!w_cs_sel) begin
                        // Withdrawal: release the bus, pointer untouched.
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule : dcpu_bus_arbiter
`default_nettype wire

// File: tb/tb_dcpu_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dcpu_bus_arbiter
// Description : Self-checking bench for dcpu_bus_arbiter. A transaction-level
//               model (current owner, grant age, last served) predicts every
//               output each cycle; directed sequences pin the model with
//               hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcpu_bus_arbiter;

    localparam int TIMEOUT = 15;
    localparam int M0_PRIO = 1;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_m0_addr = '0, i_m0_dat = '0, i_m1_addr = '0, i_m1_dat = '0;
    logic        i_m0_we = 1'b0, i_m0_cs = 1'b0, i_m1_we = 1'b0, i_m1_cs = 1'b0;
    logic [15:0] i_s_dat = '0;
    logic        i_s_ack = 1'b0;
    logic [15:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cs;
    logic [1:0]  o_grant;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    dcpu_bus_arbiter #(
        .TIMEOUT (TIMEOUT),
        .M0_PRIO (M0_PRIO)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_m0_addr (i_m0_addr),
        .i_m0_dat  (i_m0_dat),
        .i_m0_we   (i_m0_we),
        .i_m0_cs   (i_m0_cs),
        .o_m0_dat  (o_m0_dat),
        .o_m0_ack  (o_m0_ack),
        .o_m0_err  (o_m0_err),
        .i_m1_addr (i_m1_addr),
        .i_m1_dat  (i_m1_dat),
        .i_m1_we   (i_m1_we),
        .i_m1_cs   (i_m1_cs),
        .o_m1_dat  (o_m1_dat),
        .o_m1_ack  (o_m1_ack),
        .o_m1_err  (o_m1_err),
        .o_s_addr  (o_s_addr),
        .o_s_dat   (o_s_dat),
        .o_s_we    (o_s_we),
        .o_s_cs    (o_s_cs),
        .i_s_dat   (i_s_dat),
        .i_s_ack   (i_s_ack),
        .o_grant   (o_grant)
    );

    // ------------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: who owns the bus, for how many cycles, who was last
    // served. -1 means the bus is idle.
    // ------------------------------------------------------------------------
    int mdl_owner = -1;
    int mdl_age   = 0;
    int mdl_last  = (M0_PRIO != 0) ? 1 : 0;

    function automatic logic owner_cs();
        return (mdl_owner == 1) ? i_m1_cs : i_m0_cs;
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mdl_owner <= -1;
            mdl_age   <= 0;
            mdl_last  <= (M0_PRIO != 0) ? 1 : 0;
        end else if (mdl_owner < 0) begin
            if (i_m0_cs && i_m1_cs) begin
                mdl_owner <= 1 - mdl_last;
                mdl_age   <= 1;
            end else if (i_m0_cs) begin
                mdl_owner <= 0;
                mdl_age   <= 1;
            end else if (i_m1_cs) begin
                mdl_owner <= 1;
                mdl_age   <= 1;
            end
        end else if (owner_cs() && (i_s_ack || mdl_age == TIMEOUT)) begin
            mdl_last  <= mdl_owner;
            mdl_owner <= -1;
        end else if (!owner_cs()) begin
            mdl_owner <= -1;
        end else begin
            mdl_age <= mdl_age + 1;
        end
    end

    // Expected output vector:
    // {grant, s_cs, s_we, s_addr, s_dat, m0_ack, m0_err, m0_dat, m1_ack, m1_err, m1_dat}
    function automatic logic [71:0] calc();
        logic [1:0]  g;
        logic        scs, swe, a0, e0, a1, e1, cs, fin_ack, fin_tmo;
        logic [15:0] sa, sd, d0, d1;
        g = 2'b00; scs = 1'b0; swe = 1'b0; sa = '0; sd = '0;
        a0 = 1'b0; e0 = 1'b0; d0 = '0; a1 = 1'b0; e1 = 1'b0; d1 = '0;
        if (mdl_owner == 0) g = 2'b01;
        if (mdl_owner == 1) g = 2'b10;
        if (mdl_owner >= 0) begin
            cs      = owner_cs();
            scs     = cs;
            swe     = cs & ((mdl_owner == 1) ? i_m1_we : i_m0_we);
            sa      = (mdl_owner == 1) ? i_m1_addr : i_m0_addr;
            sd      = (mdl_owner == 1) ? i_m1_dat  : i_m0_dat;
            fin_ack = cs & i_s_ack;
            fin_tmo = cs & ~i_s_ack & (mdl_age == TIMEOUT);
            if (mdl_owner == 0) begin
                a0 = fin_ack | fin_tmo;
                e0 = fin_tmo;
                d0 = fin_tmo ? 16'hFFFF : i_s_dat;
            end else begin
                a1 = fin_ack | fin_tmo;
                e1 = fin_tmo;
                d1 = fin_tmo ? 16'hFFFF : i_s_dat;
            end
        end
        return {g, scs, swe, sa, sd, a0, e0, d0, a1, e1, d1};
    endfunction

    // Acks the model predicted last cycle, used by the random masters to
    // know when their transfer has completed.
    logic seen_ack0 = 1'b0;
    logic seen_ack1 = 1'b0;

    task automatic compare_cycle();
        logic [71:0] e;
        e = calc();
        chkv("bus_vs_model",
             {o_grant, o_s_cs, o_s_we, o_s_addr, o_s_dat, o_m0_ack, o_m0_err, o_m0_dat,
              o_m1_ack, o_m1_err, o_m1_dat}, e);
        seen_ack0 = e[35];
        seen_ack1 = e[17];
    endtask

    always @(negedge i_clk) compare_cycle();

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_m0_cs = 1'b0; i_m1_cs = 1'b0; i_m0_we = 1'b0; i_m1_we = 1'b0;
        i_s_ack = 1'b0;
    endtask

    task automatic step_master(input logic acked, inout logic cs, inout logic [15:0] addr,
                               inout logic [15:0] dat, inout logic we);
        if (cs) begin
            if (acked) begin
                cs   = ($urandom_range(0, 1) == 1);
                addr = 16'($urandom);
                dat  = 16'($urandom);
                we   = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 39) == 0) begin
                cs = 1'b0;
            end
        end else begin
            addr = 16'($urandom);
            dat  = 16'($urandom);
            we   = 1'($urandom_range(0, 1));
            cs   = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic run_random(input int cycles, input int ack_pct);
        for (int i = 0; i < cycles; i++) begin
            nxt();
            step_master(seen_ack0, i_m0_cs, i_m0_addr, i_m0_dat, i_m0_we);
            step_master(seen_ack1, i_m1_cs, i_m1_addr, i_m1_dat, i_m1_we);
            i_s_ack = (int'($urandom_range(0, 99)) < ack_pct);
            i_s_dat = 16'($urandom);
        end
    endtask

    // Round-robin pattern with both masters requesting and a zero-wait slave.
    logic [1:0] rr_exp [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset: outputs zero even with active inputs ----
        i_m0_cs = 1'b1; i_m0_addr = 16'h1111; i_s_ack = 1'b1; i_s_dat = 16'h2222;
        repeat (3) @(posedge i_clk);
        #1;
        chk2 ("rst_grant",  o_grant,  2'b00);
        chk1 ("rst_s_cs",   o_s_cs,   1'b0);
        chk16("rst_s_addr", o_s_addr, 16'h0000);
        chk1 ("rst_m0_ack", o_m0_ack, 1'b0);
        chk16("rst_m0_dat", o_m0_dat, 16'h0000);
        clear_inputs();
        nxt();
        i_reset_n = 1'b1;
        nxt();
        mid();
        chk2("post_rst_idle", o_grant, 2'b00);

        // ---- both request from reset: m0, bubble, m1, bubble, m0 ----
        nxt();
        i_m0_cs = 1'b1; i_m1_cs = 1'b1; i_s_ack = 1'b1; i_s_dat = 16'hA5A5;
        for (int k = 0; k < 5; k++) begin
            nxt();
            mid();
            chk2("rr_grant", o_grant, rr_exp[k]);
            chk1("rr_ack0", o_m0_ack, rr_exp[k][0]);
            chk1("rr_ack1", o_m1_ack, rr_exp[k][1]);
        end
        nxt();
        clear_inputs();

        // ---- single read, slave acks one cycle after grant ----
        nxt();
        i_m0_addr = 16'h0010; i_m0_we = 1'b0; i_m0_cs = 1'b1;
        mid();
        chk1("lat_cs_n", o_s_cs, 1'b0);
        nxt();
        mid();
        chk1 ("lat_cs_n1",   o_s_cs,   1'b1);
        chk16("lat_addr",    o_s_addr, 16'h0010);
        chk1 ("lat_ack_n1",  o_m0_ack, 1'b0);
        nxt();
        i_s_ack = 1'b1; i_s_dat = 16'hBEEF;
        mid();
        chk1 ("lat_ack_n2",  o_m0_ack, 1'b1);
        chk16("lat_dat",     o_m0_dat, 16'hBEEF);
        chk1 ("lat_ack1_n2", o_m1_ack, 1'b0);
        nxt();
        clear_inputs();
        mid();
        chk2("lat_idle", o_grant, 2'b00);

        // ---- m1 withdraws mid-grant; pending m0 served after ----
        nxt();
        i_m0_cs = 1'b1; i_m1_cs = 1'b1; i_m1_addr = 16'h4444;
        nxt();
        mid();
        chk2("wd_grant_m1", o_grant, 2'b10);
        nxt();
        i_m1_cs = 1'b0;
        mid();
        chk1("wd_no_ack", o_m1_ack, 1'b0);
        chk1("wd_s_cs",   o_s_cs,   1'b0);
        nxt();
        mid();
        chk2("wd_idle", o_grant, 2'b00);
        nxt();
        mid();
        chk2("wd_grant_m0", o_grant, 2'b01);
        nxt();
        i_s_ack = 1'b1;
        mid();
        chk1("wd_m0_ack", o_m0_ack, 1'b1);
        nxt();
        clear_inputs();

        // ---- m1 write with no slave ack: timeout on the 15th grant cycle ----
        nxt();
        i_m1_addr = 16'h8000; i_m1_dat = 16'h1234; i_m1_we = 1'b1; i_m1_cs = 1'b1;
        i_s_dat = 16'h7777;
        for (int k = 1; k <= TIMEOUT; k++) begin
            nxt();
            mid();
            chk2("to_grant", o_grant, 2'b10);
            if (k < TIMEOUT) begin
                chk1("to_early_err", o_m1_err, 1'b0);
            end else begin
                chk1 ("to_err",  o_m1_err, 1'b1);
                chk1 ("to_ack",  o_m1_ack, 1'b1);
                chk16("to_dat",  o_m1_dat, 16'hFFFF);
                chk16("to_addr", o_s_addr, 16'h8000);
                chk1 ("to_we",   o_s_we,   1'b1);
            end
        end
        nxt();
        clear_inputs();
        mid();
        chk2("to_idle", o_grant, 2'b00);

        // ---- slave ack coincides with the timeout cycle: ack wins ----
        nxt();
        i_m0_cs = 1'b1; i_s_dat = 16'h5A5A;
        for (int k = 1; k <= TIMEOUT; k++) begin
            nxt();
            if (k == TIMEOUT) i_s_ack = 1'b1;
            mid();
            if (k == TIMEOUT) begin
                chk1 ("tie_ack", o_m0_ack, 1'b1);
                chk1 ("tie_err", o_m0_err, 1'b0);
                chk16("tie_dat", o_m0_dat, 16'h5A5A);
            end
        end
        nxt();
        clear_inputs();

        // ---- reset during GRANT0 ----
        nxt();
        i_m0_cs = 1'b1;
        nxt();
        i_m1_cs = 1'b1; i_s_ack = 1'b1; i_reset_n = 1'b0;
        #1;
        chk1("rstg_s_cs",  o_s_cs,   1'b0);
        chk2("rstg_grant", o_grant,  2'b00);
        chk1("rstg_ack",   o_m0_ack, 1'b0);
        chk1("rstg_err",   o_m0_err, 1'b0);
        nxt();
        i_s_ack = 1'b0;
        nxt();
        i_reset_n = 1'b1;
        nxt();
        mid();
        chk2("rstg_rearb_m0", o_grant, 2'b01);
        nxt();
        clear_inputs();

        // ---- randomized traffic against the model ----
        run_random(600, 60);
        run_random(600, 5);
        run_random(300, 0);
        nxt();
        clear_inputs();
        repeat (3) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dcpu_bus_arbiter
`default_nettype wire

// File: doc/dcpu_bus_arbiter.md
DCPU_BUS_ARBITER -- requirements
Module: dcpu_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max grant cycles without slave ack before abort (1..255).
REQ-002 Parameter M0_PRIO, default 1, meaning master 0 (CPU) wins the first arbitration after reset when 1.
REQ-003 i_clk  in  1  system clock; single clock domain, all state on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_m0_addr, i_m1_addr  in  16 each  master word address.
REQ-006 i_m0_dat, i_m1_dat  in  16 each  master write data.
REQ-007 i_m0_we, i_m1_we  in  1 each  master write enable.
REQ-008 i_m0_cs, i_m1_cs  in  1 each  master request, held until ack or err.
REQ-009 o_m0_dat, o_m1_dat  out  16 each  read data to master.
REQ-010 o_m0_ack, o_m1_ack  out  1 each  transfer complete.
REQ-011 o_m0_err, o_m1_err  out  1 each  transfer aborted by timeout.
REQ-012 o_s_addr, o_s_dat  out  16 each  slave address and write data.
REQ-013 o_s_we, o_s_cs  out  1 each  slave write enable and select.
REQ-014 i_s_dat  in  16  slave read data; i_s_ack  in  1  slave ack.
REQ-015 o_grant  out  2  one-hot current grant {m1,m0}; 00 when idle.

Function
REQ-016 FSM states IDLE, GRANT0, GRANT1; state registered.
REQ-017 IDLE: if exactly one cs high, next state is that master's GRANT.
REQ-018 IDLE, both cs high: grant the master not served last (round-robin pointer).
REQ-019 IDLE: o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0; all acks/errs 0.
REQ-020 GRANTn: o_s_addr/o_s_dat/o_s_we/o_s_cs combinationally forwarded from master n; o_s_we gated by i_mn_cs.
REQ-021 GRANTn: o_mn_ack = i_s_ack & i_mn_cs combinationally; o_mn_dat = i_s_dat; non-granted master sees ack=0, dat=0.
REQ-022 GRANTn with ack: next state IDLE, round-robin pointer set to n; one idle bubble cycle between transfers.
REQ-023 GRANTn with i_mn_cs low and no ack (master withdraws): next state IDLE, no ack, pointer unchanged.
REQ-024 Timeout counter, 8 bit, cleared on entering GRANT, increments each GRANT cycle without ack.
REQ-025 Counter equal to TIMEOUT-1 with no ack: o_mn_err=1 and o_mn_ack=1 for that cycle, o_mn_dat=16'hFFFF, next state IDLE, pointer set to n.
REQ-026 Ack on the same cycle the timeout fires: ack wins, o_mn_err=0.
REQ-027 Latency: request in IDLE at cycle N, o_s_cs high at N+1; zero-wait slave acks at N+1.
REQ-028 o_grant registered, equals state decode.

Reset
REQ-029 i_reset_n low: state IDLE, counter 0, pointer=M0_PRIO?1:0 (pointer value = last served), all outputs 0, asynchronously and immediately.
REQ-030 Reset asserted mid-grant: slave cs drops with reset, no ack or err issued; first post-reset arbitration follows REQ-029.
REQ-031 Deassertion synchronised externally; block makes no assumption beyond first rising edge after release.

Structure
REQ-032 Shared package dcpu_pkg holds state encoding (IDLE=0, GRANT0=1, GRANT1=2), master id constants, bus width constant 16.
REQ-033 One sub-module dcpu_bus_timer: 8-bit clear/increment counter with terminal flag against TIMEOUT.
REQ-034 No other hierarchy; arbitration and muxing in top module.

Verification
REQ-035 m0 read addr 0x0010, slave acks 1 cycle later with 0xBEEF -> o_s_cs at N+1, o_m0_ack at N+2, o_m0_dat=0xBEEF.
REQ-036 m0 and m1 request together from reset -> m0 granted first, m1 next after one idle cycle; repeat -> alternates m0,m1,m0.
REQ-037 m1 write 0x1234 to 0x8000, no slave ack, TIMEOUT=15 -> o_m1_err=o_m1_ack=1 on 15th grant cycle, dat 0xFFFF, then IDLE.
REQ-038 Slave ack on same cycle as timeout -> ack only, err=0.
REQ-039 i_reset_n low during GRANT0 -> o_s_cs=0 same cycle, o_grant=00, no ack; after release m0 wins arbitration.
REQ-040 m1 drops cs mid-grant -> IDLE next cycle, no ack, pending m0 granted following cycle.
